rt_proc_interface: RTL and testbench

- Clocked network interface between a synchronous processor core and the asynchronous router's processor port.
- TX side: converts a valid/ready stream into flits and injects them with the router's 2-phase (toggle) req/ack bundled-data protocol.
- RX side: acts as the 2-phase responder for the router's processor output, buffering flits in a small FIFO that drains through valid/ready.
- One instance per router node, sharing the node's coordinates.

---
 rtl/rt_proc_interface_pkg.sv | 10 +
 rtl/rt_proc_interface_if.sv | 26 ++
 rtl/rt_proc_interface_toggle_sync.sv | 13 +
 rtl/rt_proc_interface.sv | 88 ++++++++
 tb/tb_rt_proc_interface.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rt_proc_interface_pkg.sv
// rt_proc_interface_pkg: TX FSM states and flit field offsets shared by the processor interface.
package rt_proc_interface_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} tx_state_e;
    function automatic int payload_w(input int n, input int cw);
        return n - 2*cw - 2;
    endfunction
    function automatic int dest_lsb(input int n, input int cw);
        return n - 2*cw;
    endfunction
endpackage

// File: rtl/rt_proc_interface_if.sv
// rt_proc_interface_if: processor valid/ready streams and router toggle-handshake bundles.
interface rt_proc_interface_if #(parameter int n = 32, parameter int CW = 1);
    logic tx_valid;
    logic tx_ready;
    logic [CW-1:0] tx_dest_x;
    logic [CW-1:0] tx_dest_y;
    logic [n-2*CW-3:0] tx_payload;
    logic out_req;
    logic out_ack;
    logic [n-1:0] out_data;
    logic in_req;
    logic in_ack;
    logic [n-1:0] in_data;
    logic rx_valid;
    logic rx_ready;
    logic [n-1:0] rx_data;
    logic rx_misroute;
    modport slave(
        input tx_valid, tx_dest_x, tx_dest_y, tx_payload, out_ack, in_req, in_data, rx_ready,
        output tx_ready, out_req, out_data, in_ack, rx_valid, rx_data, rx_misroute
    );
    modport master(
        output tx_valid, tx_dest_x, tx_dest_y, tx_payload, out_ack, in_req, in_data, rx_ready,
        input tx_ready, out_req, out_data, in_ack, rx_valid, rx_data, rx_misroute
    );
endinterface

// File: rtl/rt_proc_interface_toggle_sync.sv
// rt_proc_interface_toggle_sync: multi-flop synchronizer for an asynchronous toggle signal.
module rt_proc_interface_toggle_sync #(parameter int STAGES = 2) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ff <= '0;
        else ff <= {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/rt_proc_interface.sv
// rt_proc_interface: processor-side 2-phase bundled-data injector and receiver for one router node.
module rt_proc_interface
    import rt_proc_interface_pkg::*;
#(
    parameter int n = 32,
    parameter int CW = 1,
    parameter int SRCX = 0,
    parameter int SRCY = 0,
    parameter int RX_DEPTH = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst_n,
    rt_proc_interface_if.slave bus
);
    localparam int PW = payload_w(n, CW);
    localparam int DL = dest_lsb(n, CW);
    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] SX = CW'(SRCX);
    localparam logic [CW-1:0] SY = CW'(SRCY);
    typedef struct packed {
        logic [CW-1:0] dest_x;
        logic [CW-1:0] dest_y;
        logic dir_x;
        logic dir_y;
        logic [PW-1:0] payload;
    } flit_t;
    flit_t tx_flit;
    tx_state_e state_q, state_d;
    logic ack_s, req_s, out_req_q, tx_ready_q, phase_q, push, pop;
    logic [n-1:0] out_data_q;
    logic [n-1:0] mem [RX_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    rt_proc_interface_toggle_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk(clk), .rst_n(rst_n), .d(bus.out_ack), .q(ack_s)
    );
    rt_proc_interface_toggle_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk(clk), .rst_n(rst_n), .d(bus.in_req), .q(req_s)
    );
    assign tx_flit = {bus.tx_dest_x, bus.tx_dest_y, bus.tx_dest_x > SX, bus.tx_dest_y > SY, bus.tx_payload};
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (bus.tx_valid && tx_ready_q) state_d = SETUP;
        end else if (state_q == SETUP) begin
            state_d = WAIT_ACK;
        end else if (state_q != WAIT_ACK || ack_s == out_req_q) begin
            state_d = IDLE;
        end
    end
    // out_data is loaded one cycle ahead of the req toggle so it is settled at the router
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            tx_ready_q <= 1'b0;
            out_req_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            tx_ready_q <= (state_d == IDLE);
            if (state_q == IDLE && state_d == SETUP) out_data_q <= tx_flit;
            if (state_q == SETUP) out_req_q <= ~out_req_q;
        end
    assign push = (req_s != phase_q) && (cnt_q < (AW+1)'(RX_DEPTH));
    assign pop = (cnt_q != '0) && bus.rx_ready;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            phase_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (push) phase_q <= ~phase_q;
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[wr_q] <= bus.in_data;
    assign bus.tx_ready = tx_ready_q;
    assign bus.out_req = out_req_q;
    assign bus.out_data = out_data_q;
    assign bus.in_ack = phase_q;
    assign bus.rx_valid = (cnt_q != '0);
    assign bus.rx_data = mem[rd_q];
    assign bus.rx_misroute = mem[rd_q][DL +: 2*CW] != {SX, SY};
endmodule

// File: tb/tb_rt_proc_interface.sv
// tb_rt_proc_interface: randomized scoreboard bench with toggle-handshake responders for rt_proc_interface.
module tb_rt_proc_interface;
    localparam int N = 32;
    localparam int CW = 1;
    localparam int PW = N - 2*CW - 2;
    localparam int SRCX = 0;
    localparam int SRCY = 0;
    logic clk = 0;
    logic rst_n = 1;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit hold = 0;
    bit rx_done = 0;
    logic exp_req = 0;
    logic [N-1:0] q_tx[$];
    logic [N-1:0] q_rx[$];
    int q_cyc[$];
    logic q_req[$];
    logic tm_last = 0;
    bit tm_have = 0;
    logic [N-1:0] tm_cur;
    logic [N-1:0] tm_e;
    logic [N-1:0] rm_e;
    int tm_rc = 0;

    rt_proc_interface_if #(.n(N), .CW(CW)) bus();
    rt_proc_interface #(.n(N), .CW(CW), .SRCX(SRCX), .SRCY(SRCY), .RX_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial forever #4 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference flit: fields placed by arithmetic from the destination and payload
    function automatic logic [N-1:0] tx_model(input int dx, input int dy, input logic [PW-1:0] pl);
        logic [N-1:0] f;
        f = N'(pl);
        f = f + (N'(dx) << (N-CW)) + (N'(dy) << (N-2*CW));
        f = f + (N'(dx > SRCX) << (PW+1)) + (N'(dy > SRCY) << PW);
        return f;
    endfunction

    function automatic logic rx_mis(input logic [N-1:0] d);
        return (d >> (N-2*CW)) != N'((SRCX << CW) | SRCY);
    endfunction

    task automatic send_tx(input int dx, input int dy, input logic [PW-1:0] pl, input bit wait_done);
        bit ok = 0;
        @(posedge clk); #1;
        bus.tx_dest_x = CW'(dx);
        bus.tx_dest_y = CW'(dy);
        bus.tx_payload = pl;
        bus.tx_valid = 1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.tx_ready) ok = 1;
        end
        if (ok) begin
            exp_req = ~exp_req;
            q_tx.push_back(tx_model(dx, dy, pl));
            q_cyc.push_back(cyc + 1);
            q_req.push_back(exp_req);
        end
        chk("tx_accept", ok, 1);
        @(posedge clk); #1 bus.tx_valid = 0;
        if (wait_done) begin
            ok = 0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                ok = bus.tx_ready;
            end
            chk("tx_ready_return", ok, 1);
        end
    endtask

    task automatic send_rx(input logic [N-1:0] d);
        bus.in_data = d;
        #1 bus.in_req = ~bus.in_req;
        q_rx.push_back(d);
    endtask

    task automatic wait_rx_ack(input string name, input int lim);
        bit ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(posedge clk); #1;
            ok = (bus.in_ack == bus.in_req);
        end
        chk(name, ok, 1);
    endtask

    task automatic drain_rx();
        @(posedge clk); #1 bus.rx_ready = 1;
        for (int i = 0; i < 100 && q_rx.size() != 0; i++) @(negedge clk);
        chk("rx_drained", q_rx.size(), 0);
        @(negedge clk);
        chk("rx_valid_empty", bus.rx_valid, 0);
    endtask

    initial begin
        bus.out_ack = 0;
        bus.in_req = 0;
        bus.in_data = '0;
        bus.tx_valid = 0;
        bus.tx_dest_x = '0;
        bus.tx_dest_y = '0;
        bus.tx_payload = '0;
        bus.rx_ready = 0;
        fork
            forever @(posedge clk) cyc++;
            forever begin
                @(bus.out_req);
                #10;
                if (!hold || !rst_n) bus.out_ack = bus.out_req;
            end
            forever @(negedge clk) begin
                if (!rst_n) begin
                    tm_last = 0;
                    tm_have = 0;
                end else if (bus.out_req !== tm_last) begin
                    if (q_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: out_req=%b with no packet pending", bus.out_req);
                    end else begin
                        tm_e = q_tx.pop_front();
                        chk("tx_data", bus.out_data, tm_e);
                        chk("tx_req_phase", bus.out_req, q_req.pop_front());
                        chk("tx_req_latency", cyc - q_cyc.pop_front(), 1);
                        tm_cur = tm_e;
                        tm_have = 1;
                        tm_rc = cyc;
                    end
                    tm_last = bus.out_req;
                end else if (tm_have && bus.tx_ready) begin
                    chk("tx_ready_latency", cyc - tm_rc, 4);
                    tm_have = 0;
                end else if (tm_have) begin
                    chk("tx_data_hold", bus.out_data, tm_cur);
                end
            end
            forever @(negedge clk) begin
                if (rst_n && bus.rx_valid && bus.rx_ready) begin
                    if (q_rx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: rx_data=%h with nothing expected", bus.rx_data);
                    end else begin
                        rm_e = q_rx.pop_front();
                        chk("rx_data", bus.rx_data, rm_e);
                        chk("rx_misroute", bus.rx_misroute, rx_mis(rm_e));
                    end
                end
            end
        join_none
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_req", bus.out_req, 0);
        chk("rst_in_ack", bus.in_ack, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_tx_ready", bus.tx_ready, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("tx_ready_at_release", bus.tx_ready, 0);
        @(negedge clk);
        chk("tx_ready_after_release", bus.tx_ready, 1);

        send_tx(1, 1, 28'hFFFFFFE, 1);
        send_tx(1, 0, 28'hFFFFFFD, 1);

        @(posedge clk); #1 send_rx(32'h0EEEEEEE);
        wait_rx_ack("rx_ack_single", 3);
        @(negedge clk);
        chk("rx_valid_single", bus.rx_valid, 1);
        drain_rx();

        @(posedge clk); #1 bus.rx_ready = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 send_rx(32'h0AAAAAA0 + N'(k));
            wait_rx_ack("rx_ack_fill", 5);
        end
        @(posedge clk); #1 send_rx(32'h0AAAAAA4);
        repeat (6) @(posedge clk);
        #1 chk("rx_full_withheld", bus.in_ack == bus.in_req, 0);
        bus.rx_ready = 1;
        @(posedge clk); #1 bus.rx_ready = 0;
        chk("rx_push_blocked_on_pop", bus.in_ack == bus.in_req, 0);
        @(posedge clk); #1 chk("rx_fifth_acked", bus.in_ack == bus.in_req, 1);
        drain_rx();

        @(posedge clk); #1 send_rx(32'h5DDDDDDD);
        wait_rx_ack("rx_ack_misroute", 5);
        drain_rx();

        rx_done = 0;
        fork
            for (int k = 0; k < 20; k++) send_tx($urandom_range(0, 1), $urandom_range(0, 1), PW'($urandom), 1);
            begin
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk); #1 send_rx(N'($urandom));
                    wait_rx_ack("rx_ack_random", 200);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
                rx_done = 1;
            end
            while (!rx_done) begin
                @(posedge clk); #1 bus.rx_ready = 1'($urandom_range(0, 1));
            end
        join
        drain_rx();

        hold = 1;
        send_tx(0, 1, PW'($urandom), 0);
        for (int i = 0; i < 10 && bus.out_req !== exp_req; i++) @(negedge clk);
        chk("tx_req_before_reset", bus.out_req, exp_req);
        #1 rst_n = 0;
        bus.in_req = 0;
        exp_req = 0;
        #1;
        chk("rst_mid_out_req", bus.out_req, 0);
        chk("rst_mid_tx_ready", bus.tx_ready, 0);
        chk("rst_mid_out_data", bus.out_data, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        hold = 0;
        send_tx(1, 1, PW'($urandom), 1);

        repeat (5) @(posedge clk);
        chk("tx_queue_empty", q_tx.size(), 0);
        chk("rx_queue_empty", q_rx.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
